booth_divider: RTL and testbench

BOOTH_DIVIDER -- requirements
Module: booth_divider

---
 rtl/booth_pkg.sv | 14 +
 rtl/booth_div_step.sv | 26 ++
 rtl/booth_divider.sv | 132 +++++++++++++
 tb/tb_booth_divider.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared constants and FSM state type for the Booth divider family.
// Pure declarations: no latency, no flow control.
package booth_pkg;

  localparam int DEFAULT_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/booth_div_step.sv
// One radix-2 non-restoring iteration on magnitudes: shift, add/subtract |D|, quotient bit.
// Purely combinational, zero latency; no flow control.
module booth_div_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic [WIDTH-1:0] quo_in,
  input  logic [WIDTH:0]   dvsr,
  output logic [WIDTH:0]   rem_out,
  output logic [WIDTH-1:0] quo_out
);

  logic [WIDTH:0] shifted;

  // Partial remainder may wrap in the shift; the add/subtract brings it back into range.
  always_comb begin
    shifted = {rem_in[WIDTH-1:0], quo_in[WIDTH-1]};
    if (rem_in[WIDTH]) begin
      rem_out = shifted + dvsr;
    end else begin
      rem_out = shifted - dvsr;
    end
    quo_out = {quo_in[WIDTH-2:0], ~rem_out[WIDTH]};
  end

endmodule

// File: rtl/booth_divider.sv
// Signed iterative divider; WIDTH+2 cycles from accepted start to valid (1 cycle for /0 and MIN/-1).
// start is sampled only in IDLE; starts while busy or in DONE are dropped, nothing is queued.
module booth_divider
  import booth_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t state, state_nxt;

  logic [CW-1:0]    cnt;
  logic [WIDTH:0]   rem_q, dvsr_q, rem_step, rem_fix;
  logic [WIDTH-1:0] quo_q, quo_step;
  logic [WIDTH-1:0] dvd_mag, dvsr_mag;
  logic             quo_neg, rem_neg, dbz_q, ovf_q;
  logic             is_zero, is_ovf;
  logic             load, step_en, fix_en, publish;

  assign is_zero  = (divisor == '0);
  assign is_ovf   = (dividend == MOST_NEG) && (divisor == '1);
  assign dvd_mag  = dividend[WIDTH-1] ? (WIDTH'(0) - dividend) : dividend;
  assign dvsr_mag = divisor[WIDTH-1]  ? (WIDTH'(0) - divisor)  : divisor;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = (is_zero || is_ovf) ? DONE : CALC;
      CALC: if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy    = (state == CALC) || (state == FIX);
    load    = (state == IDLE) && start;
    step_en = (state == CALC);
    fix_en  = (state == FIX);
    publish = (state == DONE);
  end

  booth_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .quo_in  (quo_q),
    .dvsr    (dvsr_q),
    .rem_out (rem_step),
    .quo_out (quo_step)
  );

  // A negative final partial remainder is restored by one last add of |D|.
  assign rem_fix = rem_q[WIDTH] ? (rem_q + dvsr_q) : rem_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvsr_q  <= '0;
      quo_neg <= 1'b0;
      rem_neg <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (load) begin
      cnt     <= '0;
      dvsr_q  <= {1'b0, dvsr_mag};
      quo_neg <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
      rem_neg <= dividend[WIDTH-1];
      dbz_q   <= is_zero;
      ovf_q   <= is_ovf;
      if (is_zero) begin
        quo_q <= '1;
        rem_q <= {dividend[WIDTH-1], dividend};
      end else if (is_ovf) begin
        quo_q <= MOST_NEG;
        rem_q <= '0;
      end else begin
        quo_q <= dvd_mag;
        rem_q <= '0;
      end
    end else if (step_en) begin
      cnt   <= cnt + CW'(1);
      rem_q <= rem_step;
      quo_q <= quo_step;
    end else if (fix_en) begin
      rem_q <= rem_neg ? ((WIDTH+1)'(0) - rem_fix) : rem_fix;
      quo_q <= quo_neg ? (WIDTH'(0) - quo_q) : quo_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid       <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      valid <= publish;
      if (publish) begin
        quotient    <= quo_q;
        remainder   <= rem_q[WIDTH-1:0];
        div_by_zero <= dbz_q;
        overflow    <= ovf_q;
      end
    end
  end

endmodule

// File: tb/tb_booth_divider.sv
// Self-checking bench for booth_divider at WIDTH=16: directed vectors plus randomized ops vs a reference model.
`timescale 1ns/1ps
module tb_booth_divider;

  localparam int W = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         valid;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic         overflow;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] tv_a [7] = '{16'd100, 16'hFF9C, 16'd100, 16'h8000, 16'h8000, 16'd5, 16'd1000};
  logic [15:0] tv_b [7] = '{16'd7, 16'd7, 16'hFFF9, 16'hFFFF, 16'h0001, 16'd0, 16'd33};
  logic [33:0] tv_exp [7] = '{{16'h000E, 16'h0002, 2'b00}, {16'hFFF2, 16'hFFFE, 2'b00},
                              {16'hFFF2, 16'h0002, 2'b00}, {16'h8000, 16'h0000, 2'b01},
                              {16'h8000, 16'h0000, 2'b00}, {16'hFFFF, 16'h0005, 2'b10},
                              {16'h001E, 16'h000A, 2'b00}};
  int tv_lat [7] = '{18, 18, 18, 1, 18, 1, 18};

  always #5 clk = ~clk;

  booth_divider #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .valid       (valid),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .overflow    (overflow)
  );

  // Reference: plain integer division (truncating), with the two special cases by rule.
  function automatic logic [33:0] ref_div(input logic [15:0] a, input logic [15:0] b);
    int ai, bi, qi, ri;
    ai = int'($signed(a));
    bi = int'($signed(b));
    if (bi == 0) return {16'hFFFF, a, 2'b10};
    if (ai == -32768 && bi == -1) return {16'h8000, 16'h0000, 2'b01};
    qi = ai / bi;
    ri = ai % bi;
    return {qi[15:0], ri[15:0], 2'b00};
  endfunction

  function automatic int ref_lat(input logic [15:0] a, input logic [15:0] b);
    if (b == 16'h0000 || (a == 16'h8000 && b == 16'hFFFF)) return 1;
    return W + 2;
  endfunction

  // Issue one start and wait (bounded) for valid; lat=0 means no valid within the budget.
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        output logic [33:0] got, output int lat, output logic busy1);
    @(negedge clk);
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; got = '0; busy1 = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 1) busy1 = busy;
      if (valid) begin
        lat = k;
        got = {quotient, remainder, div_by_zero, overflow};
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; dividend = 16'd9; divisor = 16'd2;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({busy, valid, quotient, remainder, div_by_zero, overflow} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h required 0", {busy, valid, quotient, remainder, div_by_zero, overflow});
    end
    @(negedge clk);
    start = 1'b0; reset = 1'b0;
  endtask

  task automatic test_directed();
    logic [33:0] got;
    int lat;
    logic b1;
    for (int i = 0; i < 7; i++) begin
      do_div(tv_a[i], tv_b[i], got, lat, b1);
      n_checks++;
      if (got !== tv_exp[i]) begin
        n_fail++;
        $display("FAIL directed_result[%0d] %h/%h: got %h required %h", i, tv_a[i], tv_b[i], got, tv_exp[i]);
      end
      n_checks++;
      if (lat !== tv_lat[i]) begin
        n_fail++;
        $display("FAIL directed_latency[%0d]: got %0d required %0d", i, lat, tv_lat[i]);
      end
      n_checks++;
      if (b1 !== (tv_lat[i] != 1)) begin
        n_fail++;
        $display("FAIL directed_busy[%0d]: got %b required %b", i, b1, tv_lat[i] != 1);
      end
      @(posedge clk); #1;
      n_checks++;
      if (valid !== 1'b0) begin
        n_fail++;
        $display("FAIL valid_pulse_width[%0d]: got %b required 0", i, valid);
      end
      repeat (3) @(posedge clk);
      #1;
      n_checks++;
      if ({quotient, remainder, div_by_zero, overflow} !== tv_exp[i]) begin
        n_fail++;
        $display("FAIL result_hold[%0d]: got %h required %h", i, {quotient, remainder, div_by_zero, overflow}, tv_exp[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a, b;
    logic [33:0] got, exp;
    int lat;
    logic b1;
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      case ($urandom_range(0, 9))
        0: b = 16'h0000;
        1: b = 16'hFFFF;
        2: a = 16'h8000;
        3: begin a = 16'h8000; b = 16'hFFFF; end
        4: b = 16'($urandom_range(1, 9));
        default: ;
      endcase
      exp = ref_div(a, b);
      do_div(a, b, got, lat, b1);
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL random_result %h/%h: got %h required %h", a, b, got, exp);
      end
      n_checks++;
      if (lat !== ref_lat(a, b)) begin
        n_fail++;
        $display("FAIL random_latency %h/%h: got %0d required %0d", a, b, lat, ref_lat(a, b));
      end
    end
  endtask

  task automatic test_busy_ignore();
    logic [33:0] got, exp;
    int lat, extra;
    exp = ref_div(16'd1234, 16'd56);
    @(negedge clk);
    start = 1'b1; dividend = 16'd1234; divisor = 16'd56;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; got = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (k == 5) begin start = 1'b1; dividend = 16'd7; divisor = 16'd1; end
      if (k == 6) start = 1'b0;
      if (valid) begin
        lat = k;
        got = {quotient, remainder, div_by_zero, overflow};
        break;
      end
    end
    n_checks++;
    if (got !== exp || lat !== 18) begin
      n_fail++;
      $display("FAIL busy_ignore_result: got %h lat %0d required %h lat 18", got, lat, exp);
    end
    extra = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (valid) extra++;
    end
    n_checks++;
    if (extra !== 0) begin
      n_fail++;
      $display("FAIL busy_ignore_no_queue: got %0d extra valids required 0", extra);
    end
  endtask

  task automatic test_back_to_back();
    logic [33:0] got;
    int lat;
    logic b1;
    do_div(16'd300, 16'd17, got, lat, b1);
    n_checks++;
    if (got !== ref_div(16'd300, 16'd17) || lat !== 18) begin
      n_fail++;
      $display("FAIL b2b_first: got %h lat %0d required %h lat 18", got, lat, ref_div(16'd300, 16'd17));
    end
    @(posedge clk);
    do_div(16'h8000, 16'd3, got, lat, b1);
    n_checks++;
    if (got !== ref_div(16'h8000, 16'd3) || lat !== 18) begin
      n_fail++;
      $display("FAIL b2b_second: got %h lat %0d required %h lat 18", got, lat, ref_div(16'h8000, 16'd3));
    end
    do_div(16'hFC18, 16'hFFE1, got, lat, b1);
    n_checks++;
    if (got !== ref_div(16'hFC18, 16'hFFE1) || lat !== 18) begin
      n_fail++;
      $display("FAIL b2b_in_valid_cycle: got %h lat %0d required %h lat 18", got, lat, ref_div(16'hFC18, 16'hFFE1));
    end
  endtask

  task automatic test_reset_mid();
    logic [33:0] got;
    int lat, seen;
    logic b1;
    @(negedge clk);
    start = 1'b1; dividend = 16'd4321; divisor = 16'd9;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    n_checks++;
    if (busy !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_busy_before: got %b required 1", busy);
    end
    reset = 1'b1;
    #1;
    n_checks++;
    if ({busy, valid, quotient, remainder, div_by_zero, overflow} !== 36'd0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: got %h required 0", {busy, valid, quotient, remainder, div_by_zero, overflow});
    end
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk); #1;
      if (valid) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_valid: got %0d valids required 0", seen);
    end
    do_div(16'd1000, 16'd33, got, lat, b1);
    n_checks++;
    if (got !== {16'h001E, 16'h000A, 2'b00} || lat !== 18) begin
      n_fail++;
      $display("FAIL reset_mid_recover: got %h lat %0d required %h lat 18", got, lat, {16'h001E, 16'h000A, 2'b00});
    end
  endtask

  task automatic test_first_start_after_reset();
    logic [33:0] got;
    int lat;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b1; dividend = 16'd77; divisor = 16'd5;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0; got = '0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk); #1;
      if (valid) begin
        lat = k;
        got = {quotient, remainder, div_by_zero, overflow};
        break;
      end
    end
    n_checks++;
    if (got !== ref_div(16'd77, 16'd5) || lat !== 18) begin
      n_fail++;
      $display("FAIL first_start_after_reset: got %h lat %0d required %h lat 18", got, lat, ref_div(16'd77, 16'd5));
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_directed();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_first_start_after_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
